// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline boundary registers.
// Holds the ID/EX payload layout and the NOP bubble.
package pipe_pkg;

  localparam int ID_EX_W   = 141;

  // ID/EX packing: {a, b, d2, td, aluc, wreg, wmem, lw, instr}, instr in the LSBs.
  localparam int INSTR_LSB = 0;
  localparam int INSTR_W   = 32;
  localparam int LW_BIT    = 32;
  localparam int WMEM_BIT  = 33;
  localparam int WREG_BIT  = 34;
  localparam int ALUC_LSB  = 35;
  localparam int ALUC_W    = 5;
  localparam int TD_LSB    = 40;
  localparam int TD_W      = 5;
  localparam int D2_LSB    = 45;
  localparam int B_LSB     = 77;
  localparam int A_LSB     = 109;
  localparam int WORD_W    = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0020;

  localparam logic [ID_EX_W-1:0] ID_EX_BUBBLE = {{(ID_EX_W-32){1'b0}}, NOP_INSTR};

  // Builds an ID/EX payload from its fields.
  function automatic logic [ID_EX_W-1:0] pack_id_ex(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] d2,
    input logic [4:0]  td,
    input logic [4:0]  aluc,
    input logic        wreg,
    input logic        wmem,
    input logic        lw,
    input logic [31:0] instr
  );
    return {a, b, d2, td, aluc, wreg, wmem, lw, instr};
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle around one pipeline boundary register.
// valid/ready: a beat transfers on a rising edge where valid && ready are both 1;
// the sender holds valid and data stable until that edge, ready never depends
// combinationally on valid, and flush discards whatever would transfer.
interface pipe_stage_reg_if #(
  parameter int W = 141
);
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic         flush;

  // Environment side: drives the upstream beat, downstream ready and flush.
  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data
  );

  // Stage side.
  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter used for stage bring-up statistics.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register: main entry plus one skid entry, flush-to-bubble,
// and saturating stall/flush statistics.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                   PAYLOAD_W = ID_EX_W,
  parameter logic [PAYLOAD_W-1:0] BUBBLE    = ID_EX_BUBBLE,
  parameter int                   CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  pipe_stage_reg_if.slave    bus,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  logic                 main_valid;
  logic [PAYLOAD_W-1:0] main_payload;
  logic                 skid_valid;
  logic [PAYLOAD_W-1:0] skid_payload;

  logic accept;
  logic consume;
  logic stall_inc;
  logic flush_inc;

  // in_ready comes straight from a register so out_ready never reaches it.
  assign bus.in_ready  = !skid_valid;
  assign bus.out_valid = main_valid;
  assign bus.out_data  = main_valid ? main_payload : BUBBLE;

  assign accept  = bus.in_valid && !skid_valid;
  assign consume = main_valid && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid   <= 1'b0;
      main_payload <= BUBBLE;
      skid_valid   <= 1'b0;
      skid_payload <= '0;
    end else if (bus.flush) begin
      main_valid   <= 1'b0;
      main_payload <= BUBBLE;
      skid_valid   <= 1'b0;
    end else if (!main_valid || consume) begin
      if (skid_valid) begin
        main_valid   <= 1'b1;
        main_payload <= skid_payload;
        skid_valid   <= 1'b0;
      end else if (accept) begin
        main_valid   <= 1'b1;
        main_payload <= bus.in_data;
      end else begin
        main_valid   <= 1'b0;
      end
    end else if (accept) begin
      skid_valid   <= 1'b1;
      skid_payload <= bus.in_data;
    end
  end

  // A flush counts only if it threw away a held beat or one arriving that cycle.
  assign stall_inc = main_valid && !bus.out_ready;
  assign flush_inc = bus.flush && (main_valid || skid_valid || accept);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and random checks of pipe_stage_reg against a two-deep FIFO model.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  pipe_stage_reg_if #(.W(ID_EX_W)) bus ();

  pipe_stage_reg #(
    .PAYLOAD_W (ID_EX_W),
    .BUBBLE    (ID_EX_BUBBLE),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: beats the stage should be holding, oldest first
  logic [ID_EX_W-1:0] exp_q[$];
  int stall_m;
  int flush_m;
  int checks;
  int errors;

  task automatic chk(input string tag, input logic [ID_EX_W-1:0] obs,
                     input logic [ID_EX_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int sz;
    logic [ID_EX_W-1:0] exp_data;
    sz = exp_q.size();
    exp_data = (sz > 0) ? exp_q[0] : ID_EX_BUBBLE;
    chk({tag, ".out_valid"}, ID_EX_W'(bus.out_valid), ID_EX_W'(sz > 0));
    chk({tag, ".out_data"},  bus.out_data, exp_data);
    chk({tag, ".in_ready"},  ID_EX_W'(bus.in_ready), ID_EX_W'(sz < 2));
    chk({tag, ".stall_cnt"}, ID_EX_W'(stall_cnt), ID_EX_W'(stall_m));
    chk({tag, ".flush_cnt"}, ID_EX_W'(flush_cnt), ID_EX_W'(flush_m));
  endtask

  // One rising edge: the model advances from the inputs present before it.
  task automatic edge_update();
    logic v, r, f;
    logic [ID_EX_W-1:0] d;
    int sz;
    v  = bus.in_valid;
    r  = bus.out_ready;
    f  = bus.flush;
    d  = bus.in_data;
    sz = exp_q.size();
    @(posedge clk);
    if (sz > 0 && !r && stall_m < SAT) stall_m++;
    if (f) begin
      if ((sz > 0 || (v && sz < 2)) && flush_m < SAT) flush_m++;
      exp_q.delete();
    end else begin
      if (sz > 0 && r) void'(exp_q.pop_front());
      if (v && sz < 2) exp_q.push_back(d);
    end
  endtask

  // driver: apply inputs, clock once, check at the falling edge
  task automatic step(input string tag, input logic v, input logic [ID_EX_W-1:0] d,
                      input logic r, input logic f);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    bus.flush     = f;
    edge_update();
    @(negedge clk);
    check_all(tag);
  endtask

  function automatic logic [ID_EX_W-1:0] rnd_payload();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[ID_EX_W-1:0];
  endfunction

  initial begin
    checks  = 0;
    errors  = 0;
    stall_m = 0;
    flush_m = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;

    @(negedge clk);
    check_all("reset");
    rst = 1'b0;

    // streaming at full rate
    for (int i = 1; i <= 8; i++) step("stream", 1'b1, ID_EX_W'(i), 1'b1, 1'b0);
    chk("stream_last", bus.out_data, ID_EX_W'(8));

    // back-pressure into skid, then drain in order
    step("bp_acc5", 1'b1, ID_EX_W'(5), 1'b1, 1'b0);
    step("bp_acc6", 1'b1, ID_EX_W'(6), 1'b0, 1'b0);
    step("bp_hold7a", 1'b1, ID_EX_W'(7), 1'b0, 1'b0);
    step("bp_hold7b", 1'b1, ID_EX_W'(7), 1'b0, 1'b0);
    chk("bp_stall3", ID_EX_W'(stall_cnt), ID_EX_W'(3));
    chk("bp_in_ready0", ID_EX_W'(bus.in_ready), '0);
    step("drain5", 1'b1, ID_EX_W'(7), 1'b1, 1'b0);
    chk("drain_sees6", bus.out_data, ID_EX_W'(6));
    step("drain6", 1'b1, ID_EX_W'(7), 1'b1, 1'b0);
    chk("drain_sees7", bus.out_data, ID_EX_W'(7));
    step("drain7", 1'b0, '0, 1'b1, 1'b0);

    // flush with both entries full
    step("fill_a", 1'b1, ID_EX_W'(10), 1'b0, 1'b0);
    step("fill_b", 1'b1, ID_EX_W'(11), 1'b0, 1'b0);
    step("flush_full", 1'b0, '0, 1'b0, 1'b1);
    chk("flush_bubble", bus.out_data, ID_EX_W'(32'h20));
    chk("flush_cnt1", ID_EX_W'(flush_cnt), ID_EX_W'(1));

    // flush against a simultaneous accept of 9 and consume of 8
    step("pre8", 1'b1, ID_EX_W'(8), 1'b1, 1'b0);
    chk("sees8_in_flush", bus.out_data, ID_EX_W'(8));
    step("flush_acc9", 1'b1, ID_EX_W'(9), 1'b1, 1'b1);
    step("after_flush", 1'b0, '0, 1'b1, 1'b0);
    chk("no9", ID_EX_W'(bus.out_valid), '0);

    // stall counter saturation
    step("sat_load", 1'b1, ID_EX_W'(12), 1'b0, 1'b0);
    for (int i = 0; i < (1 << CNT_W) + 5; i++) step("sat_hold", 1'b0, '0, 1'b0, 1'b0);
    chk("stall_sat", ID_EX_W'(stall_cnt), ID_EX_W'(SAT));

    // asynchronous reset between edges with both entries full
    step("rst_fill", 1'b1, ID_EX_W'(13), 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    edge_update();
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    stall_m = 0;
    flush_m = 0;
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    step("first_after_rst", 1'b1, ID_EX_W'(14), 1'b1, 1'b0);
    chk("first_after_rst_data", bus.out_data, ID_EX_W'(14));

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 3) != 0), rnd_payload(),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
    end
    for (int i = 0; i < 3; i++) step("rand_drain", 1'b0, '0, 1'b1, 1'b0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline register that replaces the fixed, always-advancing ID/EX latch between decode and execute. It carries an opaque payload under a valid/ready handshake and absorbs one beat of back-pressure in a skid entry. It injects a configurable bubble on flush and keeps saturating stall and flush counters for bring-up. One instance per pipeline boundary: IF/ID, ID/EX, EX/MEM, MEM/WB.

## Interface
- PAYLOAD_W, 141, payload width. ID/EX packing is {a[31:0], b[31:0], d2[31:0], td[4:0], aluc[4:0], wreg, wmem, lw, instr[31:0]}, instr in the LSBs.
- BUBBLE, 141'h20, payload presented when the stage holds nothing. The default is the NOP instr 32'b100000 with all controls 0.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  stage clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream beat present
- in_data  in  PAYLOAD_W  upstream payload
- in_ready  out  1  stage can accept a beat this cycle
- out_valid  out  1  stage presents a valid beat
- out_data  out  PAYLOAD_W  presented payload; equals BUBBLE when out_valid=0
- out_ready  in  1  downstream consumes the beat this cycle
- flush  in  1  discard all held and incoming beats (branch/jump taken)
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
- flush_cnt  out  CNT_W  cycles with flush=1 that discarded at least one valid beat, saturating

## Operation
- Two entries: main (drives out_*) and skid. Each entry has a valid bit and a payload.
- in_ready = !skid_valid. It is registered-derived, with no combinational path from out_ready.
- Accept condition: in_valid && in_ready. Consume condition: out_valid && out_ready.
- Update rules when flush=0:
  - main empty, or consumed: main loads skid if skid_valid, otherwise the accepted beat, otherwise becomes empty.
  - main held: an accepted beat goes to skid.
  - main consumed while skid full: skid moves to main and skid empties. in_ready was 0, so no beat is accepted that cycle.
- Ordering is strict FIFO; no beat is ever duplicated or dropped except by flush.
- flush=1: both valid bits clear at the edge and any concurrent accept is discarded. The main payload register loads BUBBLE.
  - Flush overrides a simultaneous accept and a simultaneous consume.
  - The downstream still sees the pre-flush beat during the flush cycle, as the branch resolves in EX.
- out_data = main_valid ? main_payload : BUBBLE. An empty stage therefore always shows a NOP with WREG/WMEM/LW = 0.
- Counters: increment by 1 and stick at 2^CNT_W-1. Both count in the flush cycle as well.

## Timing
- Reset (asynchronous, immediate):
  - main_valid = skid_valid = 0
  - out_valid = 0, out_data = BUBBLE
  - in_ready = 1
  - stall_cnt = flush_cnt = 0
- Latency: a beat accepted at edge N appears on out_* after edge N, one cycle.
- Throughput: 1 beat/cycle while out_ready=1.
- When out_ready drops, the stage accepts exactly one more beat (into skid); in_ready falls after that edge.
- in_ready recovers 1 cycle after skid drains.
- Reset asserted mid-transfer drops all beats; the first accept is possible in the first cycle after rst deasserts.

## Structure
- Package pipe_pkg holds:
  - ID/EX field offsets and widths (A_LSB, B_LSB, D2_LSB, TD_LSB, ALUC_LSB, WREG_BIT, WMEM_BIT, LW_BIT, INSTR_LSB)
  - ID_EX_W = 141
  - NOP_INSTR = 32'h0000_0020
  - ID_EX_BUBBLE
- Sub-module sat_counter (parameter W; ports clk, rst, inc, count) is instantiated twice for the statistics.

## Test plan
- Reset, then stream payloads 1..8 with out_ready=1 -> out_data shows 1..8 on consecutive cycles, one cycle after each accept; stall_cnt=0.
- Accept 5, 6, then drop out_ready for 3 cycles with in_valid=1 offering 7 -> 6 lands in skid and in_ready=0; 7 is held upstream; stall_cnt=3. After out_ready rises: 5, 6, 7 in order.
- Stall with both entries full, assert flush for 1 cycle -> next cycle out_valid=0, out_data=141'h20, in_ready=1; flush_cnt=1.
- Flush coinciding with accept of payload 9 and consume of 8 -> 8 seen during the flush cycle, 9 never appears.
- Hold out_valid=1, out_ready=0 for 2^CNT_W+5 cycles (CNT_W=4 build) -> stall_cnt saturates at 15.
- Assert rst asynchronously between edges with both entries full -> out_valid drops to 0 and in_ready rises to 1 without a clock edge.
